// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute/writeback sequencer for the Aeolus 4-bit datapath
// Owns PC, IR and the Z/V flags; every output is decoded from state and IR.
module control_sequencer #(
  parameter int PC_W     = 4,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      instr_in,
  input  logic            alu_zero,
  input  logic            alu_overflow,
  output logic [PC_W-1:0] pc_out,
  output logic            fetch_en,
  output logic [8:0]      alu_op,
  output logic [3:0]      imm_out,
  output logic            imm_sel,
  output logic            acc_we,
  output logic            halted
);

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_WRITEBACK = 3'd3;
  localparam logic [2:0] ST_HALT      = 3'd4;

  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JV  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            z_q, z_d;
  logic            v_q, v_d;

  logic [3:0] opcode;
  logic       is_alu;
  logic       is_ldi;
  logic       take_jump;
  logic [8:0] alu_onehot;

  assign opcode = ir_q[7:4];

  always_comb begin
    is_alu     = (opcode >= 4'h1) && (opcode <= 4'h9);
    is_ldi     = (opcode == OP_LDI);
    // Jumps see the flags left by the last flag-writing instruction, not their own WRITEBACK.
    take_jump  = (opcode == OP_JMP) ||
                 ((opcode == OP_JZ) && z_q) ||
                 ((opcode == OP_JV) && v_q);
    alu_onehot = '0;
    if (is_alu) begin
      alu_onehot = 9'd1 << (opcode - 4'd1);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    v_d     = v_q;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d    = instr_in;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = (opcode == OP_HLT) ? ST_HALT : ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        state_d = ST_FETCH;
        if (is_alu) begin
          z_d = alu_zero;
          v_d = alu_overflow;
        end else if (is_ldi) begin
          z_d = (ir_q[3:0] == 4'h0);
          v_d = 1'b0;
        end
        pc_d = take_jump ? PC_W'(ir_q[3:0]) : pc_q + PC_W'(1);
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= PC_RST;
      ir_q    <= 8'h00;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      v_q     <= v_d;
    end
  end

  assign pc_out   = pc_q;
  assign imm_out  = ir_q[3:0];
  assign fetch_en = (state_q == ST_FETCH);
  assign alu_op   = (state_q == ST_EXECUTE) ? alu_onehot : 9'h000;
  assign acc_we   = (state_q == ST_WRITEBACK) && (is_alu || is_ldi);
  assign imm_sel  = (state_q == ST_WRITEBACK) && is_ldi;
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
// An instruction-level model pushes per-phase expectations; the cycle loop pops and compares them.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr_in;
  logic       alu_zero;
  logic       alu_overflow;
  logic [3:0] pc_out;
  logic       fetch_en;
  logic [8:0] alu_op;
  logic [3:0] imm_out;
  logic       imm_sel;
  logic       acc_we;
  logic       halted;

  bit [7:0] prog [16];
  bit       zf   [16];
  bit       vf   [16];

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_pc  [$];
  logic [8:0] exp_op  [$];
  logic [3:0] exp_imm [$];
  logic [2:0] exp_wb  [$];

  logic [3:0] m_pc;
  logic       m_z, m_v, m_halt;

  always #5 clk = ~clk;

  assign instr_in     = prog[pc_out];
  assign alu_zero     = zf[pc_out];
  assign alu_overflow = vf[pc_out];

  control_sequencer #(.PC_W(4), .RESET_PC(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_in     (instr_in),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .pc_out       (pc_out),
    .fetch_en     (fetch_en),
    .alu_op       (alu_op),
    .imm_out      (imm_out),
    .imm_sel      (imm_sel),
    .acc_we       (acc_we),
    .halted       (halted)
  );

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      prog[i] = 8'h00;
      zf[i]   = 1'b0;
      vf[i]   = 1'b0;
    end
  endtask

  task automatic clear_model();
    exp_pc.delete();
    exp_op.delete();
    exp_imm.delete();
    exp_wb.delete();
    m_pc   = 4'h0;
    m_z    = 1'b0;
    m_v    = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // ISA-level reference: one entry per instruction, exp_wb = {halt, acc_we, imm_sel}.
  task automatic model_push(input int n, output int ncyc);
    ncyc = 0;
    for (int i = 0; i < n && !m_halt; i++) begin
      logic [7:0] ins;
      logic [3:0] opc;
      logic [3:0] imm;
      ins = prog[m_pc];
      opc = ins[7:4];
      imm = ins[3:0];
      exp_pc.push_back(m_pc);
      exp_imm.push_back(imm);
      ncyc += 4;
      if (opc >= 4'h1 && opc <= 4'h9) begin
        exp_op.push_back(9'd1 << (opc - 4'd1));
        exp_wb.push_back(3'b010);
        m_z  = zf[m_pc];
        m_v  = vf[m_pc];
        m_pc = m_pc + 4'd1;
      end else if (opc == 4'hA) begin
        exp_op.push_back(9'h000);
        exp_wb.push_back(3'b011);
        m_z  = (imm == 4'h0);
        m_v  = 1'b0;
        m_pc = m_pc + 4'd1;
      end else if (opc == 4'hF) begin
        exp_op.push_back(9'h000);
        exp_wb.push_back(3'b100);
        m_halt = 1'b1;
      end else begin
        exp_op.push_back(9'h000);
        exp_wb.push_back(3'b000);
        if (opc == 4'hB || (opc == 4'hC && m_z) || (opc == 4'hD && m_v))
          m_pc = imm;
        else
          m_pc = m_pc + 4'd1;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    logic [3:0] epc;
    logic [8:0] eop;
    logic [3:0] eimm;
    logic [2:0] ewb;
    if (exp_pc.size() * 4 < n) begin
      errors++;
      $display("FAIL scoreboard_short have=%0d need=%0d", exp_pc.size() * 4, n);
      return;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      case (c % 4)
        0: begin
          epc = exp_pc.pop_front();
          checks++;
          if ({fetch_en, halted, alu_op, acc_we} !== {1'b1, 1'b0, 9'h000, 1'b0}) begin
            errors++;
            $display("FAIL fetch_strobes cyc=%0d got fe=%b h=%b op=%h we=%b exp fe=1 h=0 op=000 we=0",
                     c, fetch_en, halted, alu_op, acc_we);
          end
          checks++;
          if (pc_out !== epc) begin
            errors++;
            $display("FAIL fetch_pc cyc=%0d got=%h exp=%h", c, pc_out, epc);
          end
        end
        1: begin
          checks++;
          if ({fetch_en, alu_op, acc_we, imm_sel} !== {1'b0, 9'h000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL decode_strobes cyc=%0d got fe=%b op=%h we=%b sel=%b exp all 0",
                     c, fetch_en, alu_op, acc_we, imm_sel);
          end
        end
        2: begin
          eop  = exp_op.pop_front();
          eimm = exp_imm.pop_front();
          checks++;
          if ({alu_op, acc_we, fetch_en} !== {eop, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL execute_alu_op cyc=%0d got op=%h we=%b fe=%b exp op=%h we=0 fe=0",
                     c, alu_op, acc_we, fetch_en, eop);
          end
          checks++;
          if (imm_out !== eimm) begin
            errors++;
            $display("FAIL execute_imm cyc=%0d got=%h exp=%h", c, imm_out, eimm);
          end
        end
        default: begin
          ewb = exp_wb.pop_front();
          checks++;
          if (ewb[2]) begin
            if ({halted, fetch_en, alu_op, acc_we, imm_sel} !== {1'b1, 1'b0, 9'h000, 1'b0, 1'b0}) begin
              errors++;
              $display("FAIL halt_entry cyc=%0d got h=%b fe=%b op=%h we=%b sel=%b exp h=1 rest 0",
                       c, halted, fetch_en, alu_op, acc_we, imm_sel);
            end
          end else if ({halted, alu_op, acc_we, imm_sel} !== {1'b0, 9'h000, ewb[1:0]}) begin
            errors++;
            $display("FAIL writeback cyc=%0d got h=%b op=%h we=%b sel=%b exp h=0 op=000 we=%b sel=%b",
                     c, halted, alu_op, acc_we, imm_sel, ewb[1], ewb[0]);
          end
        end
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({fetch_en, alu_op, acc_we, imm_sel, halted} !== {1'b1, 9'h000, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_strobes got fe=%b op=%h we=%b sel=%b h=%b exp fe=1 rest 0",
               fetch_en, alu_op, acc_we, imm_sel, halted);
    end
    checks++;
    if ({pc_out, imm_out} !== {4'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_pc_imm got pc=%h imm=%h exp pc=0 imm=0", pc_out, imm_out);
    end
  endtask

  task automatic test_basic();
    int ncyc;
    clear_prog();
    prog[0] = 8'hA5;
    prog[1] = 8'h13;
    prog[2] = 8'hF0;
    apply_reset();
    model_push(8, ncyc);
    run_cycles(ncyc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({halted, pc_out, fetch_en, alu_op, acc_we} !== {1'b1, 4'h2, 1'b0, 9'h000, 1'b0}) begin
        errors++;
        $display("FAIL halt_hold i=%0d got h=%b pc=%h fe=%b op=%h we=%b exp h=1 pc=2 rest 0",
                 i, halted, pc_out, fetch_en, alu_op, acc_we);
      end
    end
  endtask

  task automatic test_alu_ops();
    int ncyc;
    clear_prog();
    for (int i = 0; i < 9; i++) begin
      prog[i] = {4'(i + 1), 4'(i)};
      zf[i]   = 1'(i);
      vf[i]   = 1'(i >> 1);
    end
    prog[9]  = 8'hE4;
    prog[10] = 8'hF0;
    apply_reset();
    model_push(16, ncyc);
    run_cycles(ncyc);
  endtask

  task automatic test_jumps();
    int ncyc;
    clear_prog();
    prog[3]  = 8'hB7;
    prog[7]  = 8'h13;
    prog[8]  = 8'hC2;
    prog[9]  = 8'h13;
    zf[9]    = 1'b1;
    prog[10] = 8'hCE;
    prog[14] = 8'hF0;
    apply_reset();
    model_push(16, ncyc);
    run_cycles(ncyc);
  endtask

  task automatic test_jv();
    int ncyc;
    clear_prog();
    prog[0]  = 8'h23;
    vf[0]    = 1'b1;
    prog[1]  = 8'hD5;
    prog[5]  = 8'h23;
    vf[5]    = 1'b1;
    prog[6]  = 8'hA0;
    prog[7]  = 8'hDC;
    prog[8]  = 8'hCB;
    prog[11] = 8'hF0;
    prog[12] = 8'hF0;
    apply_reset();
    model_push(16, ncyc);
    run_cycles(ncyc);
  endtask

  task automatic test_wrap();
    int ncyc;
    clear_prog();
    apply_reset();
    model_push(18, ncyc);
    run_cycles(ncyc);
  endtask

  task automatic test_reset_mid_execute();
    int ncyc;
    clear_prog();
    prog[0] = 8'h13;
    zf[0]   = 1'b1;
    vf[0]   = 1'b1;
    prog[1] = 8'h13;
    zf[1]   = 1'b1;
    vf[1]   = 1'b1;
    apply_reset();
    model_push(2, ncyc);
    run_cycles(7);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({alu_op, fetch_en, acc_we, imm_sel, halted} !== {9'h000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_strobes got op=%h fe=%b we=%b sel=%b h=%b exp op=000 fe=1 rest 0",
               alu_op, fetch_en, acc_we, imm_sel, halted);
    end
    checks++;
    if ({pc_out, imm_out} !== {4'h0, 4'h0}) begin
      errors++;
      $display("FAIL async_reset_pc got pc=%h imm=%h exp pc=0 imm=0", pc_out, imm_out);
    end
    clear_model();
    clear_prog();
    prog[0] = 8'hD5;
    prog[1] = 8'hC6;
    prog[2] = 8'hF0;
    @(posedge clk);
    #2 reset = 1'b1;
    model_push(4, ncyc);
    run_cycles(ncyc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    clear_prog();
    clear_model();
    test_reset();
    test_basic();
    test_alu_ops();
    test_jumps();
    test_jv();
    test_wrap();
    test_reset_mid_execute();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
